// File: rtl/fetch_ctrl_if.sv
// Hazard inputs and pipeline-control outputs between the datapath and fetch_ctrl.
// master is the datapath side; slave is the controller.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_dreq;
  logic             load_use;
  logic             mispredict;
  logic             halt_mem;
  logic             pc_en;
  logic             flush;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_clr;
  logic             idex_clr;
  logic             exmem_clr;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, load_use, mispredict, halt_mem,
    input  pc_en, flush, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, load_use, mispredict, halt_mem,
    output pc_en, flush, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Pipeline hazard controller: freezes, bubbles and redirects the 5-stage pipe,
// drains on a halt, and keeps saturating stall/flush statistics.
module fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic dstall;
  logic pc_en, flush;
  logic ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr;
  logic stall_inc, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign dstall = bus.mem_dreq & ~bus.dhit;

  always_comb begin
    pc_en     = 1'b0;
    flush     = 1'b0;
    ifid_en   = 1'b0;
    idex_en   = 1'b0;
    exmem_en  = 1'b0;
    memwb_en  = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    case (state)
      RUN: begin
        if (dstall) begin
          // Whole pipe frozen; older hazards stay asserted and resolve later.
        end else if (bus.halt_mem) begin
          memwb_en = 1'b1;
        end else if (bus.mispredict) begin
          pc_en    = 1'b1;
          flush    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
        end else if (bus.load_use) begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          idex_clr = 1'b1;
        end else if (!bus.ihit) begin
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          ifid_clr = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      DRAIN:   memwb_en = 1'b1;
      default: ;
    endcase
  end

  assign stall_inc = (state == RUN) && !pc_en && !flush;
  assign flush_inc = (state == RUN) && flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!dstall && bus.halt_mem) state <= DRAIN;
          if (stall_inc) stall_q <= sat_inc(stall_q);
          if (flush_inc) flush_q <= sat_inc(flush_q);
        end
        DRAIN: begin
          state  <= HALTED;
          halt_q <= 1'b1;
        end
        default: begin
          state  <= HALTED;
          halt_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.flush     = flush;
  assign bus.ifid_en   = ifid_en;
  assign bus.idex_en   = idex_en;
  assign bus.exmem_en  = exmem_en;
  assign bus.memwb_en  = memwb_en;
  assign bus.ifid_clr  = ifid_clr;
  assign bus.idex_clr  = idex_clr;
  assign bus.exmem_clr = exmem_clr;
  assign bus.halt      = halt_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random hazards against a
// cause-table reference model.
module tb_fetch_ctrl;

  logic CLK;
  logic nRST;
  int   n_tests;
  int   n_fail;

  // Reference model: halt_age < 0 running, 0 draining, >= 1 halted.
  int   halt_age;
  int   m_stall;
  int   m_flush;

  fetch_ctrl_if #(.CNT_W(16)) bus ();

  fetch_ctrl #(.CNT_W(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output vector {pc_en, flush, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr}
  function automatic logic [8:0] outs_now();
    return {bus.pc_en, bus.flush, bus.ifid_en, bus.idex_en, bus.exmem_en,
            bus.memwb_en, bus.ifid_clr, bus.idex_clr, bus.exmem_clr};
  endfunction

  // 0 normal, 1 dstall, 2 halt, 3 mispredict, 4 load_use, 5 ifetch miss
  function automatic int cause();
    if (bus.mem_dreq && !bus.dhit) return 1;
    if (bus.halt_mem)              return 2;
    if (bus.mispredict)            return 3;
    if (bus.load_use)              return 4;
    if (!bus.ihit)                 return 5;
    return 0;
  endfunction

  function automatic logic [8:0] model_outs();
    logic [8:0] tbl [6];
    tbl[0] = 9'b1_0_1111_000;
    tbl[1] = 9'b0_0_0000_000;
    tbl[2] = 9'b0_0_0001_000;
    tbl[3] = 9'b1_1_1111_110;
    tbl[4] = 9'b0_0_0111_010;
    tbl[5] = 9'b0_0_1111_100;
    if (halt_age == 0) return 9'b0_0_0001_000;
    if (halt_age > 0)  return 9'b0;
    return tbl[cause()];
  endfunction

  task automatic set_in(input logic ih, input logic dh, input logic dq,
                        input logic lu, input logic mp, input logic hm);
    bus.ihit = ih; bus.dhit = dh; bus.mem_dreq = dq;
    bus.load_use = lu; bus.mispredict = mp; bus.halt_mem = hm;
  endtask

  // Called 1 time unit after a posedge with inputs already applied.
  task automatic step(input string tag);
    logic [8:0] exp;
    int c;
    @(negedge CLK);
    exp = model_outs();
    chk({tag, "_outs"}, 32'(outs_now()), 32'(exp));
    chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
    chk({tag, "_flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
    chk({tag, "_halt"}, 32'(bus.halt), 32'(halt_age >= 1));
    c = cause();
    @(posedge CLK);
    if (halt_age < 0) begin
      if (!exp[8] && !exp[7] && m_stall < 65535) m_stall++;
      if (exp[7] && m_flush < 65535) m_flush++;
      if (c == 2) halt_age = 0;
    end else begin
      halt_age++;
    end
    #1;
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    chk("rst_halt", 32'(bus.halt), 32'd0);
    halt_age = -1;
    m_stall  = 0;
    m_flush  = 0;
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    halt_age = -1;
    m_stall  = 0;
    m_flush  = 0;
    nRST     = 1'b0;
    set_in(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Normal streaming
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      step("normal");
    end
    chk("normal_stall_zero", 32'(bus.stall_cnt), 32'd0);

    // Instruction-fetch miss for 3 cycles
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      step("imiss");
    end
    chk("imiss_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // Data stall hides a pending mispredict, which then resolves
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 1, 0, 1, 0);
      step("dstall");
    end
    set_in(1, 1, 1, 0, 1, 0);
    step("dstall_done");
    chk("dstall_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("dstall_stall_cnt", 32'(bus.stall_cnt), 32'd4);

    // Load-use with simultaneous fetch miss
    do_reset();
    set_in(0, 0, 0, 1, 0, 0);
    step("lduse_imiss");

    // Halt beats mispredict, drains, then stays halted
    do_reset();
    set_in(1, 0, 0, 0, 1, 1);
    step("halt_req");
    set_in(1, 0, 0, 0, 1, 0);
    step("drain");
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0, 0, 1, 1);
      step("halted");
    end
    chk("halted_flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // Reset out of HALTED, first cycle obeys the normal priorities
    do_reset();
    set_in(1, 0, 0, 0, 1, 0);
    step("post_halt_misp");

    // Stall counter saturation
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      step("sat");
    end
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'hFFFF);
    do_reset();

    // Random hazards
    for (int i = 0; i < 2000; i++) begin
      if (halt_age > 5 || $urandom_range(0, 99) == 0) do_reset();
      set_in($urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
